instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the core CPU. It fetches 8-bit instruction words {opcode[7:4], operand[3:0]} from instruction memory over a req/valid handshake and decodes the opcode. It then issues single-cycle register-load strobes (load_a, load_b, load_c) or a held read_en to the datapath, and handles NOP, JMP and HALT itself. It sits between the instruction store and the A/B/C register and ALU datapath.

Parameters:
PC_W, 8, program counter and instruction address width (4..16).
RESET_PC, 0, PC value loaded at reset and on every start.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins execution at RESET_PC; honoured only in IDLE or HALTED.
imem_addr  out  PC_W  instruction fetch address.
imem_req  out  1  fetch request, held until imem_valid.
imem_valid  in  1  imem_data valid this cycle; ignored unless imem_req=1.
imem_data  in  8  instruction word.
opcode  out  4  opcode of the current instruction (to ALU op select).
operand  out  4  operand field of the current instruction (immediate to datapath).
load_a  out  1  one-cycle strobe, opcode 0001.
load_b  out  1  one-cycle strobe, opcode 0010.
load_c  out  1  one-cycle strobe, opcodes 0100..1101.
read_en  out  1  readout request, opcode 0011; held until out_ready.
out_ready  in  1  readout consumer accepts this cycle.
pc  out  PC_W  current program counter.
busy  out  1  high in every state except IDLE and HALTED.
halted  out  1  high in HALTED.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, pc=RESET_PC, opcode=0, operand=0, and all strobes, imem_req, read_en, busy and halted = 0. An asserted rst_n aborts any state immediately, including a pending fetch or readout.
- States are IDLE, FETCH, DECODE, EXEC, WAIT_OUT and HALTED.
- IDLE: when start=1, pc is set to RESET_PC and the state moves to FETCH.
- FETCH: imem_req=1 and imem_addr=pc. When imem_valid=1, opcode and operand are registered and the state moves to DECODE. Back-to-back wait cycles are unbounded.
- DECODE (1 cycle), by opcode:
  - 0001, 0010, 0100..1101: go to EXEC.
  - 0011: go to WAIT_OUT.
  - 0000 (NOP): pc+1, go to FETCH.
  - 1110 (JMP): pc = zero-extended operand, go to FETCH.
  - 1111 (HALT): go to HALTED; pc is not incremented.
- EXEC (1 cycle): exactly one of load_a, load_b or load_c =1 per the decode table. pc+1, then go to FETCH.
- WAIT_OUT: read_en=1 every cycle. On the cycle with out_ready=1, read_en is still 1, pc+1, and the state moves to FETCH. read_en drops the following cycle.
- HALTED: halted=1 and pc holds. start restarts at RESET_PC and goes to FETCH.
- Strobe exclusivity: load_a, load_b, load_c and read_en are never high simultaneously. All are registered outputs, not combinational from imem_data.
- Latency per instruction, with zero-wait memory (imem_valid in the first FETCH cycle):
  - Load/ALU: 3 cycles (FETCH, DECODE, EXEC).
  - NOP/JMP: 2 cycles.
  - READOUT: 3 cycles with out_ready already high.
- PC arithmetic: pc increments modulo 2^PC_W, so all-ones wraps to 0. The JMP target is truncated/zero-extended to PC_W.
- start while busy is ignored.
- opcode and operand stay stable from DECODE until the next imem_valid capture.

Test Plan:
1. Reset then start. Program: 0x15, 0x27, 0x40, 0x3F. With zero-wait imem and out_ready=1, the bench sees:
   - load_a with operand=5 at cycle 3;
   - load_b with operand=7 at cycle 6;
   - load_c with opcode=4 at cycle 9;
   - read_en high for 1 cycle at cycle 12, then halted after fetching 0xF0.
2. Fetch backpressure: imem_valid delayed 4 cycles on each fetch -> imem_req stays high and imem_addr stable throughout; strobe timing shifts by exactly 4 cycles per instruction.
3. Readout stall: opcode 0x3 with out_ready low for 5 cycles -> read_en high for 6 consecutive cycles; pc advances only after the out_ready cycle.
4. JMP and wrap: PC_W=4, program reaches address 15 containing NOP -> next fetch at address 0. A JMP 0xE9 -> next imem_addr=9.
5. HALT/restart and start-while-busy:
   - start pulsed mid-program: ignored, pc unaffected.
   - after 0xF0: halted=1, busy=0, no imem_req.
   - new start: fetch from RESET_PC.
6. Async reset mid-WAIT_OUT (rst_n low between clock edges) -> read_en, busy and imem_req drop immediately and pc=RESET_PC. After rst_n release, the block stays IDLE until start.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: fetches {opcode, operand} words from instruction
// memory and drives one-cycle register-load strobes or a held readout request.
module instr_sequencer #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_valid,
    input  logic [7:0]      imem_data,
    output logic [3:0]      opcode,
    output logic [3:0]      operand,
    output logic            load_a,
    output logic            load_b,
    output logic            load_c,
    output logic            read_en,
    input  logic            out_ready,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);
    // Handshakes: a fetch completes on the cycle where imem_req and imem_valid are
    // both 1; a readout completes on the cycle where read_en and out_ready are both 1.
    // imem_req and read_en stay asserted, with stable address/operand, until then.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC     = 3'd3,
        S_WAIT_OUT = 3'd4,
        S_HALTED   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_OUT  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] jmp_target;
    logic            load_a_next;
    logic            load_b_next;
    logic            load_c_next;
    logic            read_en_next;

    assign jmp_target = PC_W'(operand);
    assign imem_addr  = pc;
    assign imem_req   = (state == S_FETCH);
    assign busy       = (state != S_IDLE) && (state != S_HALTED);
    assign halted     = (state == S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        load_a_next  = 1'b0;
        load_b_next  = 1'b0;
        load_c_next  = 1'b0;
        read_en_next = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_next    = RESET_PC;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP: begin
                        pc_next    = pc + PC_ONE;
                        state_next = S_FETCH;
                    end
                    OP_LDA: begin
                        load_a_next = 1'b1;
                        state_next  = S_EXEC;
                    end
                    OP_LDB: begin
                        load_b_next = 1'b1;
                        state_next  = S_EXEC;
                    end
                    OP_OUT: begin
                        read_en_next = 1'b1;
                        state_next   = S_WAIT_OUT;
                    end
                    OP_JMP: begin
                        pc_next    = jmp_target;
                        state_next = S_FETCH;
                    end
                    OP_HALT: begin
                        state_next = S_HALTED;
                    end
                    default: begin
                        load_c_next = 1'b1;
                        state_next  = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                pc_next    = pc + PC_ONE;
                state_next = S_FETCH;
            end
            S_WAIT_OUT: begin
                // read_en is still high on the accepting cycle; it drops with the move to FETCH.
                if (out_ready) begin
                    pc_next    = pc + PC_ONE;
                    state_next = S_FETCH;
                end else begin
                    read_en_next = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            opcode  <= '0;
            operand <= '0;
            load_a  <= 1'b0;
            load_b  <= 1'b0;
            load_c  <= 1'b0;
            read_en <= 1'b0;
        end else begin
            pc      <= pc_next;
            load_a  <= load_a_next;
            load_b  <= load_b_next;
            load_c  <= load_c_next;
            read_en <= read_en_next;
            if (state == S_FETCH && imem_valid) begin
                opcode  <= imem_data[7:4];
                operand <= imem_data[3:0];
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a per-cycle vector table for the basic program, then
// scoreboarded runs against an instruction-level interpreter of the program.
module tb_instr_sequencer;
    localparam int         PC_W     = 4;
    localparam logic [3:0] RESET_PC = 4'd3;
    localparam int         MEM_N    = 16;

    localparam int K_WAIT  = 1;
    localparam int K_FETCH = 2;
    localparam int K_LA    = 3;
    localparam int K_LB    = 4;
    localparam int K_LC    = 5;
    localparam int K_READ  = 6;
    localparam int K_HALT  = 7;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic            imem_valid;
    logic [7:0]      imem_data;
    logic [3:0]      opcode;
    logic [3:0]      operand;
    logic            load_a;
    logic            load_b;
    logic            load_c;
    logic            read_en;
    logic            out_ready;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;

    instr_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .opcode     (opcode),
        .operand    (operand),
        .load_a     (load_a),
        .load_b     (load_b),
        .load_c     (load_c),
        .read_en    (read_en),
        .out_ready  (out_ready),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600_000;
        $display("FAIL watchdog act=still_running req=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bench state ----------------
    typedef struct {
        int         cyc;
        logic [3:0] str;      // {read_en, load_c, load_b, load_a}
        logic       busy;
        logic       halted;
        logic       req;
        logic [3:0] addr;
        logic [3:0] op;
        logic [3:0] od;
    } vec_t;

    vec_t        tbl[11];
    logic [7:0]  mem[MEM_N];
    int          fw[64];
    int          sw[64];
    logic [31:0] exp_q[$];
    int          fetch_log[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          ss1 = -1;
    int          ss2 = -1;
    int          fidx, sidx, wcnt, scnt;
    int          rd_cycles, rd_first, la_rel, lb_rel, lc_rel;
    bit          sb_on = 1'b0;
    bit          halt_seen;
    logic        prev_halted;

    function automatic logic [31:0] ev(input int kind, input logic [3:0] op, input logic [3:0] od,
                                       input int p, input int c);
        logic [31:0] k32, p32, c32;
        k32 = kind;
        p32 = p;
        c32 = c;
        return {k32[3:0], op, od, p32[7:0], c32[11:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s act=%h req=%h", name, act, req);
    endtask

    task automatic record(input logic [31:0] e);
        if (!sb_on) return;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event act=%h req=none", e);
        end else begin
            check("event", e, exp_q.pop_front());
        end
    endtask

    // Instruction-level interpreter: walks the program and lists, with cycle numbers
    // relative to the start pulse, every observable event the sequencer should produce.
    task automatic build_expect(output int hc);
        int         c, p, fi, ri, d, kind;
        logic [7:0] ins;
        exp_q.delete();
        c  = 1;
        p  = int'(RESET_PC);
        fi = 0;
        ri = 0;
        hc = 0;
        for (int n = 0; n < 64; n++) begin
            for (int k = 0; k < fw[fi]; k++) exp_q.push_back(ev(K_WAIT, 4'h0, 4'h0, p, c + k));
            c = c + fw[fi];
            fi++;
            ins = mem[p];
            exp_q.push_back(ev(K_FETCH, ins[7:4], ins[3:0], p, c));
            d = c + 1;
            case (ins[7:4])
                4'h0: begin
                    p = (p + 1) % (1 << PC_W);
                    c = d + 1;
                end
                4'hE: begin
                    p = int'(ins[3:0]);
                    c = d + 1;
                end
                4'hF: begin
                    exp_q.push_back(ev(K_HALT, ins[7:4], ins[3:0], p, d + 1));
                    hc = d + 1;
                    return;
                end
                4'h3: begin
                    for (int k = 0; k <= sw[ri]; k++) exp_q.push_back(ev(K_READ, ins[7:4], ins[3:0], p, d + 1 + k));
                    c = d + 2 + sw[ri];
                    ri++;
                    p = (p + 1) % (1 << PC_W);
                end
                default: begin
                    kind = (ins[7:4] == 4'h1) ? K_LA : (ins[7:4] == 4'h2) ? K_LB : K_LC;
                    exp_q.push_back(ev(kind, ins[7:4], ins[3:0], p, d + 1));
                    c = d + 2;
                    p = (p + 1) % (1 << PC_W);
                end
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        int         rel;
        logic [7:0] w;
        rel = cyc - start_cyc;
        if (imem_req) begin
            w = mem[imem_addr];
            if (wcnt >= fw[fidx]) begin
                imem_valid = 1'b1;
                imem_data  = w;
                record(ev(K_FETCH, w[7:4], w[3:0], int'(imem_addr), rel));
                fetch_log.push_back(int'(imem_addr));
                wcnt = 0;
                if (fidx < 63) fidx++;
            end else begin
                imem_valid = 1'b0;
                imem_data  = 8'($urandom);
                record(ev(K_WAIT, 4'h0, 4'h0, int'(imem_addr), rel));
                wcnt++;
            end
        end else begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_data  = 8'($urandom);
        end
        if (read_en) begin
            record(ev(K_READ, opcode, operand, int'(pc), rel));
            rd_cycles++;
            if (rd_first < 0) rd_first = rel;
            if (scnt >= sw[sidx]) begin
                out_ready = 1'b1;
                scnt = 0;
                if (sidx < 63) sidx++;
            end else begin
                out_ready = 1'b0;
                scnt++;
            end
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
        if (load_a) begin
            record(ev(K_LA, opcode, operand, int'(pc), rel));
            if (la_rel < 0) la_rel = rel;
        end
        if (load_b) begin
            record(ev(K_LB, opcode, operand, int'(pc), rel));
            if (lb_rel < 0) lb_rel = rel;
        end
        if (load_c) begin
            record(ev(K_LC, opcode, operand, int'(pc), rel));
            if (lc_rel < 0) lc_rel = rel;
        end
        if (halted && !prev_halted) begin
            record(ev(K_HALT, opcode, operand, int'(pc), rel));
            halt_seen = 1'b1;
        end
        prev_halted = halted;
        start = (rel == 0) || (rel == ss1) || (rel == ss2);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_waits(input int f, input int s);
        for (int i = 0; i < 64; i++) begin
            fw[i] = f;
            sw[i] = s;
        end
    endtask

    task automatic prep_run(input int s1, input int s2);
        fidx = 0; sidx = 0; wcnt = 0; scnt = 0;
        rd_cycles = 0; rd_first = -1; la_rel = -1; lb_rel = -1; lc_rel = -1;
        halt_seen = 1'b0;
        prev_halted = halted;
        fetch_log.delete();
        ss1 = s1;
        ss2 = s2;
        start_cyc = cyc;
    endtask

    task automatic run_prog(input int s1, input int s2);
        int hc;
        build_expect(hc);
        prep_run(s1, s2);
        sb_on = 1'b1;
        for (int r = 0; r <= hc + 3; r++) cycle();
        sb_on = 1'b0;
        check("halt_reached", 32'(halt_seen), 32'd1);
        check("events_left", exp_q.size(), 0);
    endtask

    task automatic load_basic();
        mem[3] = 8'h15;
        mem[4] = 8'h27;
        mem[5] = 8'h40;
        mem[6] = 8'h3F;
        mem[7] = 8'hF0;
    endtask

    task automatic random_prog(output int s_mid);
        int         k, q, r, op, a, hc_unused;
        logic [3:0] a4;
        k = $urandom_range(3, 16);
        for (int p = 0; p < k; p++) begin
            a = (int'(RESET_PC) + p) % MEM_N;
            if (p == k - 1) begin
                mem[a] = {4'hF, 4'($urandom_range(0, 15))};
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    mem[a] = {4'h0, 4'($urandom_range(0, 15))};
                end else if (r == 1) begin
                    q = $urandom_range(p + 1, k - 1);
                    a4 = 4'((int'(RESET_PC) + q) % MEM_N);
                    mem[a] = {4'hE, a4};
                end else if (r == 2) begin
                    mem[a] = {4'h3, 4'($urandom_range(0, 15))};
                end else begin
                    op = $urandom_range(1, 12);
                    if (op >= 3) op++;
                    mem[a] = {4'(op), 4'($urandom_range(0, 15))};
                end
            end
        end
        for (int i = 0; i < 64; i++) begin
            fw[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            sw[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
        end
        build_expect(hc_unused);
        s_mid = $urandom_range(2, hc_unused - 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s_mid;
        tbl[0]  = '{0,  4'b0000, 1'b0, 1'b0, 1'b0, 4'd3, 4'h0, 4'h0};
        tbl[1]  = '{1,  4'b0000, 1'b1, 1'b0, 1'b1, 4'd3, 4'h0, 4'h0};
        tbl[2]  = '{2,  4'b0000, 1'b1, 1'b0, 1'b0, 4'd3, 4'h1, 4'h5};
        tbl[3]  = '{3,  4'b0001, 1'b1, 1'b0, 1'b0, 4'd3, 4'h1, 4'h5};
        tbl[4]  = '{4,  4'b0000, 1'b1, 1'b0, 1'b1, 4'd4, 4'h1, 4'h5};
        tbl[5]  = '{6,  4'b0010, 1'b1, 1'b0, 1'b0, 4'd4, 4'h2, 4'h7};
        tbl[6]  = '{9,  4'b0100, 1'b1, 1'b0, 1'b0, 4'd5, 4'h4, 4'h0};
        tbl[7]  = '{12, 4'b1000, 1'b1, 1'b0, 1'b0, 4'd6, 4'h3, 4'hF};
        tbl[8]  = '{13, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd7, 4'h3, 4'hF};
        tbl[9]  = '{15, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd7, 4'hF, 4'h0};
        tbl[10] = '{16, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd7, 4'hF, 4'h0};

        for (int i = 0; i < MEM_N; i++) mem[i] = 8'h00;
        rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic program, zero-wait memory, per-cycle vectors
        load_basic();
        set_waits(0, 0);
        prep_run(-1, -1);
        for (int r = 0; r <= 16; r++) begin
            for (int i = 0; i < 11; i++) begin
                if (tbl[i].cyc == r)
                    check($sformatf("vec_c%0d", r),
                          {read_en, load_c, load_b, load_a, busy, halted, imem_req, imem_addr, opcode, operand},
                          {tbl[i].str, tbl[i].busy, tbl[i].halted, tbl[i].req, tbl[i].addr, tbl[i].op, tbl[i].od});
            end
            cycle();
        end

        // fetch backpressure: every fetch waits 4 cycles
        set_waits(4, 0);
        run_prog(-1, -1);
        check("bp_load_a_cycle", la_rel, 7);
        check("bp_load_b_cycle", lb_rel, 14);
        check("bp_load_c_cycle", lc_rel, 21);
        check("bp_read_cycle", rd_first, 28);

        // readout stall: out_ready low for 5 cycles
        mem[3] = 8'h3A;
        mem[4] = 8'hF0;
        set_waits(0, 5);
        run_prog(-1, -1);
        check("stall_read_cycles", rd_cycles, 6);
        check("stall_read_first", rd_first, 3);

        // JMP and pc wrap from 15 to 0
        mem[3] = 8'hE9; mem[9] = 8'h1A; mem[10] = 8'h00; mem[11] = 8'h2B; mem[12] = 8'h5C;
        mem[13] = 8'h3D; mem[14] = 8'h00; mem[15] = 8'h00; mem[0] = 8'h61; mem[1] = 8'hF0;
        set_waits(0, 0);
        run_prog(-1, -1);
        check("jmp_fetch_count", fetch_log.size(), 10);
        check("jmp_target_addr", fetch_log[1], 9);
        check("wrap_addr", fetch_log[8], 0);

        // start pulses while busy, then halted quiet, then restart at RESET_PC
        load_basic();
        run_prog(5, 10);
        for (int i = 0; i < 3; i++) begin
            check("halted_quiet", {halted, busy, imem_req}, 3'b100);
            cycle();
        end
        set_waits(1, 1);
        run_prog(-1, -1);
        check("restart_addr", fetch_log[0], int'(RESET_PC));

        // asynchronous reset in the middle of a readout
        mem[3] = 8'h35;
        set_waits(0, 50);
        prep_run(-1, -1);
        for (int r = 0; r < 20 && rd_cycles < 3; r++) cycle();
        check("rd_before_reset", rd_cycles, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outs", {read_en, busy, imem_req, halted, load_a, load_b, load_c}, 7'b0);
        check("async_reset_pc", pc, RESET_PC);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc - 1000;
        for (int i = 0; i < 5; i++) begin
            check("idle_after_reset", {busy, imem_req, halted, read_en, pc}, {4'b0000, RESET_PC});
            cycle();
        end
        load_basic();
        set_waits(0, 0);
        run_prog(-1, -1);

        // randomized programs, memory waits, readout stalls and mid-run start pulses
        for (int t = 0; t < 20; t++) begin
            random_prog(s_mid);
            run_prog(s_mid, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
